mux_sel_pipe: RTL

Parametrised N-input, W-bit selector with a registered, back-pressured output stage for the MIPS datapath (writeback/forwarding select, PC-source select). One input beat carries a select code and N candidate words; the chosen word (or a default word for out-of-range codes) is delivered one cycle later through a valid/ready handshake. A two-entry skid buffer sustains one beat per cycle under back-pressure. Out-of-range selects are flagged per beat and counted.

---
 rtl/mips_mux_pkg.sv | 12 +
 rtl/mux_sel_pipe_skid_buf.sv | 73 +++++++
 rtl/mux_sel_pipe.sv | 84 ++++++++
 3 files changed

// File: rtl/mips_mux_pkg.sv
// Shared definitions for the MIPS datapath selector blocks.
// Default widths and the helper that locates candidate k inside a packed bus.
package mips_mux_pkg;

   localparam int DATA_W    = 32;
   localparam int DEF_ERR_W = 16;

   function automatic int slice_lo(input int k, input int w);
      return k * w;
   endfunction

endpackage

// File: rtl/mux_sel_pipe_skid_buf.sv
// Two-entry output stage: a main register driving the outputs plus one skid register.
// in_ready is registered so it never combinationally depends on out_ready.
module skid_buf
   import mips_mux_pkg::*;
#(
   parameter int PW = DATA_W + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [PW-1:0] in_pld,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [PW-1:0] out_pld
);

   logic [PW-1:0] main_q, main_d;
   logic [PW-1:0] skid_q, skid_d;
   logic          main_vld_q, main_vld_d;
   logic          skid_vld_q, skid_vld_d;
   logic          rdy_q;
   logic          acc, xfer;

   assign acc  = in_valid && rdy_q;
   assign xfer = main_vld_q && out_ready;

   always_comb begin
      main_d     = main_q;
      main_vld_d = main_vld_q;
      skid_d     = skid_q;
      skid_vld_d = skid_vld_q;
      if (main_vld_q && !xfer) begin
         // Main is stalled; a new beat can only land in the skid (empty whenever rdy_q is 1).
         if (acc) begin
            skid_d     = in_pld;
            skid_vld_d = 1'b1;
         end
      end else if (skid_vld_q) begin
         main_d     = skid_q;
         main_vld_d = 1'b1;
         skid_vld_d = 1'b0;
      end else begin
         main_vld_d = acc;
         if (acc) begin
            main_d = in_pld;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         main_q     <= '0;
         main_vld_q <= 1'b0;
         skid_vld_q <= 1'b0;
         rdy_q      <= 1'b0;
      end else begin
         main_q     <= main_d;
         main_vld_q <= main_vld_d;
         skid_vld_q <= skid_vld_d;
         rdy_q      <= !skid_vld_d;
      end
   end

   always_ff @(posedge clk) begin
      skid_q <= skid_d;
   end

   assign in_ready  = rdy_q;
   assign out_valid = main_vld_q;
   assign out_pld   = main_q;

endmodule

// File: rtl/mux_sel_pipe.sv
// N-input selector with default word for out-of-range codes, registered
// back-pressured output and a saturating out-of-range beat counter.
module mux_sel_pipe
   import mips_mux_pkg::*;
#(
   parameter int WIDTH  = DATA_W,
   parameter int NUM_IN = 4,
   parameter int SEL_W  = 3,
   parameter int ERR_W  = DEF_ERR_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [SEL_W-1:0]        sel,
   input  logic [NUM_IN*WIDTH-1:0] in_bus,
   input  logic [WIDTH-1:0]        default_in,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_sel_err,
   input  logic                    err_clr,
   output logic [ERR_W-1:0]        err_count
);

   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
      return (&v) ? v : v + ERR_W'(1);
   endfunction

   logic [WIDTH-1:0] word;
   logic             sel_err;
   logic             acc;
   logic [ERR_W-1:0] err_count_q, err_count_d;
   logic [WIDTH:0]   out_pld;

   always_comb begin
      word    = default_in;
      sel_err = 1'b1;
      for (int k = 0; k < NUM_IN; k++) begin
         if (sel == SEL_W'(k)) begin
            word    = in_bus[slice_lo(k, WIDTH) +: WIDTH];
            sel_err = 1'b0;
         end
      end
   end

   assign acc = in_valid && in_ready;

   // A clear coinciding with a counted beat leaves that beat counted.
   always_comb begin
      err_count_d = err_count_q;
      if (acc && sel_err) begin
         err_count_d = err_clr ? ERR_W'(1) : sat_inc(err_count_q);
      end else if (err_clr) begin
         err_count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_count_q <= '0;
      end else begin
         err_count_q <= err_count_d;
      end
   end

   skid_buf #(
      .PW(WIDTH + 1)
   ) u_skid (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_pld   ({sel_err, word}),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_pld  (out_pld)
   );

   assign out_data    = out_pld[WIDTH-1:0];
   assign out_sel_err = out_pld[WIDTH];
   assign err_count   = err_count_q;

endmodule
